// File: rtl/axil_master_if.sv
// rtl/axil_master_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_master_if #(
  parameter int C_DATA_W = 32,
  parameter int C_ADDR_W = 32
);
  logic [C_ADDR_W-1:0]   awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [C_DATA_W-1:0]   wdata;
  logic [C_DATA_W/8-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [C_ADDR_W-1:0]   araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [C_DATA_W-1:0]   rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_master.sv
// rtl/axil_master.sv - AXI4-Lite initiator, one outstanding single-beat command
module axil_master #(
  parameter int C_DATA_W = 32,
  parameter int C_ADDR_W = 32
) (
  input  logic                  i_m_axi_aclk,
  input  logic                  i_m_axi_areset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [C_ADDR_W-1:0]   i_cmd_addr,
  input  logic [C_DATA_W-1:0]   i_cmd_wdata,
  input  logic [C_DATA_W/8-1:0] i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [C_DATA_W-1:0]   o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_busy,
  axil_master_if.master         m_axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic [C_ADDR_W-1:0]   r_awaddr;
  logic                  r_awvalid;
  logic [C_DATA_W-1:0]   r_wdata;
  logic [C_DATA_W/8-1:0] r_wstrb;
  logic                  r_wvalid;
  logic                  r_bready;
  logic [C_ADDR_W-1:0]   r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [C_DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;

  assign w_cmd_hs  = i_cmd_valid & r_cmd_ready;
  assign w_aw_hs   = r_awvalid & m_axi.awready;
  assign w_w_hs    = r_wvalid & m_axi.wready;
  // a channel counts as done if it already completed earlier or completes now
  assign w_aw_done = ~r_awvalid | w_aw_hs;
  assign w_w_done  = ~r_wvalid | w_w_hs;

  always_ff @(posedge i_m_axi_aclk) begin
    if (i_m_axi_areset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_hs) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (i_cmd_write) begin
              r_awaddr  <= i_cmd_addr;
              r_wdata   <= i_cmd_wdata;
              r_wstrb   <= i_cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_araddr  <= i_cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (r_bready && m_axi.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= m_axi.bresp;
            r_rsp_rdata <= '0;
            r_rsp_write <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (r_arvalid && m_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_rready && m_axi.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_resp  <= m_axi.rresp;
            r_rsp_rdata <= m_axi.rdata;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_busy       = r_busy;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_write  = r_rsp_write;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_rsp_resp   = r_rsp_resp;

  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

endmodule
